// File: rtl/triangular_pkg.sv
// Shared types and constants for the triangular-root extractor.
// Debug trace in the top is enabled by TRIANGULAR_ROOT_DEBUG_EN.
package triangular_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic BLANK = 1'b0;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    LOAD = 3'b001,
    STEP = 3'b010,
    DONE = 3'b011
  } state_t;

endpackage

// File: rtl/triangular_root_if.sv
// Start/done handshake and result bus of the triangular-root extractor.
// Master drives the request, slave returns the registered result.
interface triangular_root_if
  import triangular_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] sum_input;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] remainder;
  logic             exact;
  logic             done;

  modport master (
    output start,
    output sum_input,
    input  root,
    input  remainder,
    input  exact,
    input  done
  );

  modport slave (
    input  start,
    input  sum_input,
    output root,
    output remainder,
    output exact,
    output done
  );

endinterface

// File: rtl/triangular_root_dp.sv
// Datapath: working remainder/term registers, compare, subtract and
// the result registers captured when the compare terminates.
module triangular_root_dp
  import triangular_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             capture,
  input  logic [WIDTH-1:0] sum_input,
  output logic             lt,
  output logic [WIDTH-1:0] root,
  output logic [WIDTH-1:0] remainder,
  output logic             exact
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] kp1;
  logic [WIDTH-1:0] diff;

  assign kp1  = k + 1'b1;
  assign lt   = rem < kp1;
  assign diff = rem - kp1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rem       <= {WIDTH{BLANK}};
      k         <= {WIDTH{BLANK}};
      root      <= {WIDTH{BLANK}};
      remainder <= {WIDTH{BLANK}};
      exact     <= BLANK;
    end else begin
      if (load) begin
        rem <= sum_input;
        k   <= {WIDTH{BLANK}};
      end else if (step) begin
        rem <= diff;
        k   <= kp1;
      end
      if (capture) begin
        root      <= k;
        remainder <= rem;
        exact     <= (rem == {WIDTH{BLANK}});
      end
    end
  end

endmodule

// File: rtl/triangular_root.sv
// Triangular-root extractor top: control FSM driving triangular_root_dp.
// Define TRIANGULAR_ROOT_DEBUG_EN for a simulation trace of each STEP.
module triangular_root
  import triangular_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic reset,
  triangular_root_if.slave bus
);

  state_t state;
  logic   lt;
  logic   load;
  logic   step;
  logic   capture;

  assign load    = (state == LOAD);
  assign step    = (state == STEP) && !lt;
  assign capture = (state == STEP) && lt;
  assign bus.done = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state <= LOAD;
        LOAD:    state <= STEP;
        STEP:    if (lt) state <= DONE;
        DONE:    if (!bus.start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  triangular_root_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .step      (step),
    .capture   (capture),
    .sum_input (bus.sum_input),
    .lt        (lt),
    .root      (bus.root),
    .remainder (bus.remainder),
    .exact     (bus.exact)
  );

`ifdef TRIANGULAR_ROOT_DEBUG_EN
  always @(posedge clock) begin
    if (reset && state == STEP)
      $write("%0t STEP state=%0d k=%0d rem=%0d lt=%0b\n",
             $time, state, u_dp.k, u_dp.rem, lt);
  end
`else
`endif

endmodule

// File: tb/tb_triangular_root.sv
// Directed bench for triangular_root with a result scoreboard.
// Closes the loop n -> n(n+1)/2 -> n for every 8-bit root.
module tb_triangular_root;

  localparam int W = 8;

  typedef struct {
    int root;
    int rem;
    int exact;
    int lat;
  } exp_t;

  logic clock;
  logic reset;
  exp_t sb[$];
  int   passed;
  int   total;

  triangular_root_if #(.WIDTH(W)) bus ();

  triangular_root #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic exp_t model(input int s);
    exp_t e;
    int n;
    int t;
    n = 0;
    t = 0;
    while (t + n + 1 <= s) begin
      n++;
      t += n;
    end
    e.root  = n;
    e.rem   = s - t;
    e.exact = (s == t) ? 1 : 0;
    e.lat   = n + 3;
    return e;
  endfunction

  // Starts a conversion on the next edge, counts edges (the sampling
  // edge is edge 1) until done, optionally holds start in DONE.
  task automatic run_op(input string tag, input int s, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(s));
    bus.sum_input = s[W-1:0];
    bus.start     = 1'b1;
    lat = 0;
    do begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end while (!bus.done && lat < 64);
    e = sb.pop_front();
    chk({tag, "_done"}, int'(bus.done), 1);
    chk({tag, "_root"}, int'(bus.root), e.root);
    chk({tag, "_rem"}, int'(bus.remainder), e.rem);
    chk({tag, "_exact"}, int'(bus.exact), e.exact);
    chk({tag, "_lat"}, lat, e.lat);
    for (int i = 0; i < hold; i++) begin
      bus.sum_input = W'($urandom_range(0, 255));
      @(posedge clock);
      @(negedge clock);
      chk({tag, "_hold_done"}, int'(bus.done), 1);
      chk({tag, "_hold_root"}, int'(bus.root), e.root);
      chk({tag, "_hold_rem"}, int'(bus.remainder), e.rem);
      chk({tag, "_hold_exact"}, int'(bus.exact), e.exact);
    end
    bus.start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_drop"}, int'(bus.done), 0);
    chk({tag, "_keep_root"}, int'(bus.root), e.root);
    chk({tag, "_keep_rem"}, int'(bus.remainder), e.rem);
  endtask

  initial begin
    passed        = 0;
    total         = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.sum_input = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_root", int'(bus.root), 0);
    chk("rst_rem", int'(bus.remainder), 0);
    chk("rst_exact", int'(bus.exact), 0);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_done", int'(bus.done), 0);

    run_op("s0", 0, 0);
    run_op("s10", 10, 0);
    run_op("s11", 11, 0);
    run_op("s253", 253, 0);
    run_op("s255", 255, 0);

    // Abort a long conversion in its fifth STEP cycle.
    bus.sum_input = 8'd200;
    bus.start     = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("mid_busy", int'(bus.done), 0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_root", int'(bus.root), 0);
    chk("mid_rst_rem", int'(bus.remainder), 0);
    chk("mid_rst_exact", int'(bus.exact), 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_idle", int'(bus.done), 0);
    run_op("s6", 6, 0);

    run_op("hold15", 15, 4);
    run_op("hold100", 100, 4);

    for (int n = 0; n <= 22; n++)
      run_op($sformatf("loop%0d", n), n * (n + 1) / 2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/triangular_root.md
# triangular_root

Iterative triangular-root extractor: given a sum S, it returns the largest n with n(n+1)/2 <= S, the remainder S - n(n+1)/2, and an exact flag. It is the inverse of the summation datapath: it consumes sums of the form 0+1+...+n and recovers n. It follows the same split as the summation design, with a control FSM driving a small register/ALU datapath and a start/done handshake. It sits beside the summation GDP, so benches can close the loop n -> sum -> n.

## Interface
- WIDTH, 8, width of sum input, root, remainder and internal registers
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- start  input  1  request; sampled only in IDLE
- sum_input  input  WIDTH  S, unsigned; captured in LOAD
- root  output  WIDTH  floor triangular root n (registered)
- remainder  output  WIDTH  S - n(n+1)/2 (registered)
- exact  output  1  1 when remainder == 0 (registered)
- done  output  1  result valid; high only in DONE

## Operation
- Datapath registers:
  - rem (WIDTH): working remainder.
  - k (WIDTH): terms subtracted so far.
  - Comparator: rem < k+1.
  - Subtractor: rem - (k+1).
- FSM states and transitions (3-bit encoding):
  - IDLE (000): if start = 1, go to LOAD; otherwise stay.
  - LOAD (001): rem <= sum_input, k <= 0; go to STEP.
  - STEP (010):
    - If rem < k+1: root <= k, remainder <= rem, exact <= (rem == 0); go to DONE.
    - Else: rem <= rem - (k+1), k <= k+1; stay in STEP.
  - DONE (011): hold all outputs; done = 1. If start = 1, stay. If start = 0, go to IDLE.
  - Unused encodings go to IDLE.
- Arithmetic:
  - All arithmetic is unsigned modulo 2^WIDTH.
  - k+1 cannot overflow, because the compare terminates first (for WIDTH = 8, k <= 22).
- Reset (reset = 0 at a rising edge):
  - state = IDLE.
  - rem, k, root, remainder = 0; exact = 0; done = 0.
  - Applies in any state, including mid-STEP; the partial result is discarded.
- Boundary conditions:
  - start is ignored outside IDLE and DONE.
  - sum_input changes after LOAD have no effect.
  - root, remainder and exact persist through IDLE until the next STEP->DONE transition.
  - S = 0 gives root 0, remainder 0, exact 1.
  - S = 2^WIDTH-1 must produce the correct result with no wrap.

## Timing
- Outputs are registered; done is decoded from state.
- Latency for S with floor root n, counting edges after the edge that samples start = 1 in IDLE:
  - edge 1: LOAD
  - edge 2: first STEP
  - n successful subtractions, then one failing compare
  - done rises after edge n+3, so latency = n+3 cycles.
- done falls one edge after start is seen low in DONE.
- Back-to-back operation: start may be reasserted in the first IDLE cycle.

## Configuration
- TRIANGULAR_ROOT_DEBUG_EN:
  - Defined: a simulation-only $write trace on each STEP edge prints state, k, rem and the compare result with $time.
  - Undefined: no trace code is compiled.
  - RTL behaviour and ports are identical in both cases.

## Structure
- Package triangular_pkg holds:
  - state encodings IDLE, LOAD, STEP, DONE;
  - default WIDTH;
  - the BLANK zero constant.
- The FSM lives in triangular_root.
- One sub-module, triangular_root_dp, holds:
  - the rem and k registers;
  - the comparator and subtractor;
  - the result registers.
- The FSM drives triangular_root_dp through load/step/capture strobes, and receives the lt flag (rem < k+1) back.

## Test plan
- S=0, start=1 -> done high 3 cycles after start is sampled; root=0, remainder=0, exact=1.
- S=10 -> root=4, remainder=0, exact=1, done after 7 cycles. S=11 -> root=4, remainder=1, exact=0.
- S=253 -> root=22, remainder=0, exact=1, done after 25 cycles. S=255 -> root=22, remainder=2, exact=0.
- S=200, pull reset low in the 5th STEP cycle:
  - next edge: done=0, root=0, remainder=0, exact=0, state IDLE;
  - then reset=1, S=6 -> root=3, exact=1.
- Hold start=1 in DONE for 4 cycles while changing sum_input -> done stays 1 and outputs are unchanged. Drop start -> done=0 one edge later, and outputs retain their values.
- Loop check with the summation GDP, n = 0..22: root = n, exact = 1, latency = n+3 for every n.
